logic_op_sequencer: RTL
=======================

Name: logic_op_sequencer

Overview:
Bit-serial operand feeder and result collector for the combinational two-input logical unit (a, b, func[3:0] -> out). It accepts two WIDTH-bit operand words and a 4-bit function code, presents one operand bit pair per cycle to the logical unit (LSB first), and captures the unit's returned out bit into a WIDTH-bit result word. It sits directly upstream of the logical unit and also consumes its output.

Parameters:
WIDTH, 8, operand/result word width in bits; legal range 2..32.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request to begin an operation; sampled only in IDLE
op_a  input  WIDTH  operand A word, sampled on accepted start
op_b  input  WIDTH  operand B word, sampled on accepted start
func_in  input  4  function code, sampled on accepted start
lu_out  input  1  out bit returned by the logical unit, combinationally derived from a, b, func
a  output  1  current operand A bit to the logical unit
b  output  1  current operand B bit to the logical unit
func  output  4  latched function code to the logical unit
busy  output  1  high in RUN and DONE states
result  output  WIDTH  collected result word
done  output  1  single-cycle pulse when result is complete

Behaviour:
- One clock domain; reset is asynchronous and active-high, on clk/rst.
- Reset values: state=IDLE, a=0, b=0, func=4'h0, busy=0, result=0, done=0, shift registers and bit counter=0.
- Internal state: sh_a and sh_b (WIDTH-bit shift registers), cnt (bit index, ceil(log2(WIDTH)) bits), 2-bit FSM with states IDLE, RUN, DONE.
- a = sh_a[0] and b = sh_b[0] while in RUN; both 0 in IDLE and DONE. Both are functions of registers only, with no combinational path from any input.
- func holds the last latched code until the next accepted start. It is stable for the whole of RUN.
- IDLE: when start=1, on that edge:
  - load sh_a<=op_a, sh_b<=op_b, func<=func_in;
  - clear result<=0 and cnt<=0;
  - go to RUN.
  With start=0, remain in IDLE; all outputs hold.
- RUN, each cycle:
  - result[cnt]<=lu_out;
  - sh_a and sh_b shift right by one, zero-fill at MSB;
  - cnt<=cnt+1.
  When cnt==WIDTH-1, the capture is made and the next state is DONE; cnt does not wrap inside RUN.
- DONE: done=1 for exactly this one cycle; result is stable; next state is IDLE unconditionally.
- Start handling: start is ignored in RUN and DONE, so a start in the DONE cycle is dropped. The earliest re-accept is the following IDLE cycle. op_a, op_b and func_in changing while busy have no effect.
- Latency: start accepted at edge T -> RUN for cycles T+1..T+WIDTH -> done high during cycle T+WIDTH+1 -> IDLE from T+WIDTH+2. Throughput is one operation per WIDTH+2 cycles.
- Result bit i = lu_out observed while a=op_a[i] and b=op_b[i].
- result holds after DONE until the next accepted start clears it.
- Reset mid-operation: everything returns immediately to its reset values; the partial result is discarded, no done pulse is produced, and lu_out is ignored.

Test Plan:
Bench instantiates the logicalunit with a/b/func driven from this block and out fed back to lu_out; WIDTH=8.
1. XOR: func_in=4'b0110, op_a=8'hA5, op_b=8'h3C, start pulse at edge T -> busy high from T, a/b stream bits 0..7 over cycles T+1..T+8, done one cycle at T+9, result=8'h99, then IDLE.
2. AND then OR back-to-back: func_in=4'b1000 with A5/3C -> result=8'h24. Start held high through DONE is not accepted in the DONE cycle. Then func_in=4'b1110 with the same operands, accepted next IDLE -> result=8'hBD; the result register reads 0 during the second RUN's first cycle.
3. Constant functions: func_in=4'b0000 with any operands -> result=8'h00; func_in=4'b1111 -> result=8'hFF. func output equals func_in throughout RUN.
4. Start while busy: start pulses at T+3 with op_a=8'hFF and func_in=4'b0001 during the scenario 1 run -> no effect; func stays 4'b0110 and result=8'h99.
5. Reset mid-run: assert rst asynchronously (between clock edges) at T+4 of an XOR run -> busy, done, a, b, result and func go to 0 immediately without waiting for a clock edge. No done pulse follows. After release, a fresh start completes normally with result=8'h99.

Source files
------------

// File: rtl/logic_op_sequencer.sv
// logic_op_sequencer
//   Bit-serial feeder/collector for a combinational two-input logical unit.
//   An accepted start latches two WIDTH-bit operands and a 4-bit function
//   code, then streams one operand bit pair per cycle (LSB first) to the
//   unit and gathers its returned bit into a WIDTH-bit result word.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   begin an operation (only honoured in IDLE)
//   op_a     in   operand A word, captured on accepted start
//   op_b     in   operand B word, captured on accepted start
//   func_in  in   function code, captured on accepted start
//   lu_out   in   out bit from the logical unit for the current a/b pair
//   a, b     out  current operand bits (0 outside RUN)
//   func     out  latched function code
//   busy     out  high in RUN and DONE
//   result   out  collected result word
//   done     out  one-cycle pulse when result is complete
module logic_op_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       func_in,
  input  logic             lu_out,
  output logic             a,
  output logic             b,
  output logic [3:0]       func,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last;

  assign last = (cnt == LAST);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state; start is only looked at in IDLE, so a start seen
  // during RUN or DONE is simply dropped
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // datapath: operand shifters, bit index, function latch, result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_a   <= '0;
      sh_b   <= '0;
      cnt    <= '0;
      func   <= 4'h0;
      result <= '0;
    end else if (accept) begin
      sh_a   <= op_a;
      sh_b   <= op_b;
      func   <= func_in;
      cnt    <= '0;
      result <= '0;
    end else if (state == RUN) begin
      // lu_out reflects the pair currently on a/b, i.e. bit index cnt
      result[cnt] <= lu_out;
      sh_a        <= {1'b0, sh_a[WIDTH-1:1]};
      sh_b        <= {1'b0, sh_b[WIDTH-1:1]};
      // hold at the last index; the FSM leaves RUN on this capture
      if (!last) cnt <= cnt + CW'(1);
    end
  end

  // outputs decoded from registers only; no input-to-output path
  assign a    = (state == RUN) & sh_a[0];
  assign b    = (state == RUN) & sh_b[0];
  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
